n_bit_piso_serializer: RTL and testbench
========================================

// Module: n_bit_piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter; upstream feeder of n_bit_sipo_shift_reg.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock
//  on o_serial, qualified by o_serial_valid. Back-to-back words stream with no idle
//  cycles unless GAP requests them. A one-entry holding buffer decouples the producer
//  from the shifter.
// PARAMETERS
//  WIDTH      8  bits per word; legal range >= 2
//  GAP        0  idle cycles forced between the last bit of one word and the first bit of the next
//  MSB_FIRST  1  1: transmit bit WIDTH-1 first, which matches the SIPO's left shift; 0: transmit bit 0 first
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous, active-low reset
//  i_valid         in   1      producer offers i_data
//  o_ready         out  1      block can accept; a word transfers on i_valid && o_ready at the clk edge
//  i_data          in   WIDTH  word to serialize
//  o_serial        out  1      serial bit (registered)
//  o_serial_valid  out  1      o_serial carries a data bit this cycle
//  o_first         out  1      high with the first bit of each word
//  o_last          out  1      high with the last bit of each word
//  o_busy          out  1      shifter active or holding buffer occupied
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State goes to IDLE; holding buffer and shifter are cleared.
//   - All outputs go to 0, except o_ready, which is 1.
//   - Takes effect immediately, mid-word included; the word in flight and any buffered word are discarded.
//  Storage and o_ready:
//   - Storage is a shifter plus a 1-entry holding register (hold, hold_full).
//   - o_ready = !hold_full, combinational from a register only; it never depends on i_valid.
//  FSM states and transitions:
//   - IDLE -> SHIFT on a load event.
//   - SHIFT: bit counter runs 0..WIDTH-1.
//   - At cnt==WIDTH-1, when GAP>0: go to GAP.
//   - At cnt==WIDTH-1, when GAP==0: go to SHIFT if a load event occurs, else IDLE.
//   - GAP: counts GAP cycles, then goes to SHIFT on a load event, else IDLE.
//  Load event: an edge where the shifter is free and a word is available.
//   - Shifter free means: state IDLE, or last bit with GAP==0, or the final GAP cycle.
//   - Word available means: hold_full, or accept this edge.
//   - The source is hold if hold_full (hold_full then clears).
//   - Otherwise the accepted i_data loads directly, bypassing hold.
//  Accept at an edge with no load event: the word goes into hold and hold_full sets.
//   Accept and load at the same edge with hold_full=1 cannot occur, because o_ready=0.
//  Latency and output flags:
//   - A word accepted into an IDLE block shows its first bit on o_serial in the next cycle.
//   - o_serial_valid = (state==SHIFT).
//   - o_first = SHIFT && cnt==0; o_last = SHIFT && cnt==WIDTH-1.
//   - o_serial is 0 whenever o_serial_valid=0.
//  Bit order: bit k of the word appears at cnt=k' where k'=WIDTH-1-k (MSB_FIRST=1) or k'=k (MSB_FIRST=0).
//  Throughput: with GAP=0 and the producer keeping up, o_serial_valid stays high continuously across words.
//  Word integrity: no word is dropped, duplicated or reordered under any i_valid pattern.
//   i_data is sampled only on the accept edge.
//  o_busy = (state!=IDLE) || hold_full.
// TESTING
//  1 WIDTH=8, GAP=0: accept 0xA5 at cycle 0.
//    -> Cycles 1-8: o_serial_valid=1, bits 1,0,1,0,0,1,0,1.
//    -> o_first at cycle 1, o_last at cycle 8.
//    -> SIPO loopback reads 0xA5 after the 8th bit.
//  2 i_valid held with 0x3C then 0xC3.
//    -> 16 consecutive valid bits (0x3C then 0xC3), no idle cycle.
//    -> o_ready=0 while 0xC3 waits in hold.
//  3 GAP=2, two words.
//    -> Exactly 2 cycles with o_serial_valid=0 between o_last and the next o_first.
//  4 Randomised i_valid with 4 words (0x11, 0x22, 0x33, 0x44).
//    -> Serial output is exactly 0x11, 0x22, 0x33, 0x44, in order.
//    -> o_ready is low only while hold_full=1.
//  5 Pull rst_n low after the 3rd bit of a word.
//    -> o_serial_valid=0, o_busy=0, o_ready=1 immediately.
//    -> After release, a new word 0x0F transmits intact.
//  6 MSB_FIRST=0, word 0x01.
//    -> First bit 1, then seven 0s; o_first and o_last are correct.

Source files
------------

// File: rtl/n_bit_piso_serializer_if.sv
// n_bit_piso_serializer_if
//   Bundles the serializer's word-side handshake and its serial-side outputs.
//   slave  : the serializer (consumes words, drives the serial stream)
//   master : the producer / downstream observer
// Signals
//   i_valid        producer offers i_data
//   o_ready        serializer can take a word this cycle
//   i_data         WIDTH-bit word
//   o_serial       serial bit
//   o_serial_valid o_serial carries a data bit
//   o_first/o_last first / last bit of a word
//   o_busy         shifter active or holding buffer occupied
interface n_bit_piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_serial;
    logic             o_serial_valid;
    logic             o_first;
    logic             o_last;
    logic             o_busy;

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_serial, o_serial_valid, o_first, o_last, o_busy
    );

    modport master (
        output i_valid, i_data,
        input  o_ready, o_serial, o_serial_valid, o_first, o_last, o_busy
    );
endinterface

// File: rtl/n_bit_piso_serializer.sv
// n_bit_piso_serializer
//   Parallel-in / serial-out transmitter. Words arrive on a valid/ready
//   handshake and leave one bit per clock. A one-entry holding register lets
//   the producer hand over the next word while the current one is shifting,
//   so words stream back-to-back when GAP is 0.
// Parameters
//   WIDTH      bits per word (>= 2)
//   GAP        idle cycles inserted after the last bit of every word
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of n_bit_piso_serializer_if
module n_bit_piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    n_bit_piso_serializer_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             shift_free;
    logic             load;
    logic [WIDTH-1:0] load_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gcnt_q      <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        accept     = bus.i_valid && !hold_full_q;
        // The shifter can take a new word at this edge: idle, finishing the
        // last bit with no gap to follow, or finishing the last gap cycle.
        shift_free = (state_q == S_IDLE)
                  || (state_q == S_SHIFT && cnt_q == CNT_LAST && GAP == 0)
                  || (state_q == S_GAP && gcnt_q == GAP_LAST);
        load       = shift_free && (hold_full_q || accept);
        // A buffered word always goes first; otherwise the incoming word
        // bypasses the buffer.
        load_word  = hold_full_q ? hold_q : bus.i_data;

        state_d     = state_q;
        cnt_d       = cnt_q;
        gcnt_d      = gcnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        // accept never coincides with hold_full_q, since o_ready is low then
        if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept && !load) begin
            hold_d      = bus.i_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = S_IDLE;
                else                    gcnt_d  = gcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A load overrides the fall-back to IDLE chosen above.
        if (load) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            shreg_d = load_word;
        end
    end

    assign bus.o_ready        = !hold_full_q;
    assign bus.o_serial_valid = (state_q == S_SHIFT);
    assign bus.o_serial       = bus.o_serial_valid
                              && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign bus.o_first        = bus.o_serial_valid && (cnt_q == '0);
    assign bus.o_last         = bus.o_serial_valid && (cnt_q == CNT_LAST);
    assign bus.o_busy         = (state_q != S_IDLE) || hold_full_q;
endmodule

// File: tb/tb_n_bit_piso_serializer.sv
// tb_n_bit_piso_serializer
//   Three serializer configurations share one clock and reset:
//     cfg0 GAP=0 MSB first, cfg1 GAP=2 MSB first, cfg2 GAP=0 LSB first.
//   The reference keeps, per configuration, the list of accepted words with
//   the cycle each word's first bit must appear; every output is derived from
//   that schedule and compared on every falling edge.
module tb_n_bit_piso_serializer;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vin [3];
    logic [7:0] din [3];
    logic [5:0] rout[3];   // {ready, busy, last, first, valid, serial}

    always #5 clk = ~clk;

    n_bit_piso_serializer_if #(.WIDTH(W)) b0 ();
    n_bit_piso_serializer_if #(.WIDTH(W)) b1 ();
    n_bit_piso_serializer_if #(.WIDTH(W)) b2 ();

    n_bit_piso_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    n_bit_piso_serializer #(.WIDTH(W), .GAP(2), .MSB_FIRST(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    n_bit_piso_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    assign b0.i_valid = vin[0]; assign b0.i_data = din[0];
    assign b1.i_valid = vin[1]; assign b1.i_data = din[1];
    assign b2.i_valid = vin[2]; assign b2.i_data = din[2];
    assign rout[0] = {b0.o_ready, b0.o_busy, b0.o_last, b0.o_first, b0.o_serial_valid, b0.o_serial};
    assign rout[1] = {b1.o_ready, b1.o_busy, b1.o_last, b1.o_first, b1.o_serial_valid, b1.o_serial};
    assign rout[2] = {b2.o_ready, b2.o_busy, b2.o_last, b2.o_first, b2.o_serial_valid, b2.o_serial};

    function automatic int gapv(int g); return (g == 1) ? 2 : 0; endfunction
    function automatic bit msbv(int g); return (g != 2); endfunction
    function automatic string sig(int i);
        case (i)
            0: return "serial"; 1: return "serial_valid"; 2: return "first";
            3: return "last";   4: return "busy";         default: return "ready";
        endcase
    endfunction

    int cyc = 0;
    int stq[3][$];     // scheduled first-bit cycle per accepted word
    int wq [3][$];     // the words, same order
    int nchk = 0, npass = 0;

    // observed stream, rebuilt from the DUT outputs
    int sh[3], lg[3][$];
    int run[3], maxrun[3], rlow[3], idle[3], gapseen[3];
    int first_c[3], last_c[3], firstbit[3];
    bit seen_last[3];

    function automatic void chk(string nm, int act, int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    // hold is occupied during the current cycle iff the newest word starts later
    function automatic bit mrdy(int g);
        return (stq[g].size() == 0) || (stq[g][$] <= cyc);
    endfunction

    function automatic logic [5:0] expv(int g);
        logic v = 1'b0, s = 1'b0, f = 1'b0, l = 1'b0, b = 1'b0, r = 1'b1;
        for (int i = 0; i < stq[g].size(); i++) begin
            int d, wd;
            d  = cyc - stq[g][i];
            wd = wq[g][i];
            if (d >= 0 && d < W) begin
                v = 1'b1;
                s = wd[msbv(g) ? (W - 1 - d) : d];
                f = (d == 0);
                l = (d == W - 1);
            end
            if (d >= 0 && d < W + gapv(g)) b = 1'b1;
        end
        if (!mrdy(g)) begin r = 1'b0; b = 1'b1; end
        return {r, b, l, f, v, s};
    endfunction

    task automatic model_loop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int g = 0; g < 3; g++) begin stq[g].delete(); wq[g].delete(); end
            end else begin
                for (int g = 0; g < 3; g++) begin
                    if (vin[g] && mrdy(g)) begin
                        int s;
                        s = cyc + 1;
                        if (stq[g].size() > 0 && stq[g][$] + W + gapv(g) > s)
                            s = stq[g][$] + W + gapv(g);
                        stq[g].push_back(s);
                        wq[g].push_back(int'(din[g]));
                    end
                end
                cyc = cyc + 1;
                for (int g = 0; g < 3; g++)
                    while (stq[g].size() > 0 && stq[g][0] + W + gapv(g) <= cyc) begin
                        void'(stq[g].pop_front()); void'(wq[g].pop_front());
                    end
            end
        end
    endtask

    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                logic [5:0] e;
                logic v, sr;
                e = expv(g);
                for (int i = 0; i < 6; i++)
                    chk($sformatf("cfg%0d %s cyc%0d", g, sig(i), cyc), int'(rout[g][i]), int'(e[i]));
                v  = rout[g][1];
                sr = rout[g][0];
                if (!rout[g][5]) rlow[g]++;
                if (v) begin
                    run[g]++;
                    if (run[g] > maxrun[g]) maxrun[g] = run[g];
                    sh[g] = msbv(g) ? (((sh[g] << 1) | int'(sr)) & 255)
                                    : ((sh[g] >> 1) | (int'(sr) << 7));
                end else begin
                    run[g] = 0;
                end
                if (rout[g][2]) begin
                    first_c[g] = cyc; firstbit[g] = int'(sr);
                    if (seen_last[g]) gapseen[g] = idle[g];
                end
                if (v && rout[g][3]) begin
                    lg[g].push_back(sh[g]); last_c[g] = cyc; seen_last[g] = 1'b1; idle[g] = 0;
                end else if (!v) begin
                    idle[g]++;
                end
            end
        end
    endtask

    task automatic clrm(int g);
        run[g] = 0; maxrun[g] = 0; rlow[g] = 0; idle[g] = 0; gapseen[g] = -1;
        seen_last[g] = 1'b0;
    endtask

    task automatic send(int g, logic [7:0] w, int idle_max, output int acc);
        int n;
        bit ok;
        repeat (int'($urandom_range(0, idle_max))) begin @(posedge clk); #1; end
        vin[g] = 1'b1; din[g] = w;
        n = 0; ok = 1'b0;
        while (!ok && n < 500) begin
            ok = rout[g][5];
            @(posedge clk); #1;
            n++;
        end
        vin[g] = 1'b0;
        acc = cyc;
        chk($sformatf("cfg%0d send accepted", g), int'(ok), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((rout[0][4] | rout[1][4] | rout[2][4]) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain within bound", int'(n < 3000), 1);
    endtask

    task automatic stress(int g);
        int acc;
        repeat (25) send(g, 8'($urandom_range(0, 255)), 2, acc);
    endtask

    initial begin
        int acc, base, b1s, b2s;
        for (int g = 0; g < 3; g++) begin
            vin[g] = 1'b0; din[g] = '0; sh[g] = 0; first_c[g] = 0; last_c[g] = 0;
            firstbit[g] = 0; clrm(g);
        end
        fork
            model_loop();
            cmp_loop();
        join_none
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single word, idle block: bits appear the cycle after the accept edge
        clrm(0); base = lg[0].size();
        send(0, 8'hA5, 0, acc);
        drain();
        chk("t1 word count", lg[0].size() - base, 1);
        chk("t1 word", lg[0][base], 'hA5);
        chk("t1 first cycle", first_c[0], acc);
        chk("t1 last cycle", last_c[0], acc + 7);
        chk("t1 first bit", firstbit[0], 1);

        // back-to-back: 16 contiguous bits, second word parked for 7 cycles
        clrm(0); base = lg[0].size();
        send(0, 8'h3C, 0, acc);
        send(0, 8'hC3, 0, acc);
        drain();
        chk("t2 word0", lg[0][base], 'h3C);
        chk("t2 word1", lg[0][base+1], 'hC3);
        chk("t2 contiguous bits", maxrun[0], 16);
        chk("t2 ready-low cycles", rlow[0], 7);

        // GAP=2 between two words
        clrm(1); base = lg[1].size();
        send(1, 8'h5A, 0, acc);
        send(1, 8'h96, 0, acc);
        drain();
        chk("t3 word0", lg[1][base], 'h5A);
        chk("t3 word1", lg[1][base+1], 'h96);
        chk("t3 idle between words", gapseen[1], 2);

        // randomised i_valid spacing
        base = lg[0].size();
        send(0, 8'h11, 3, acc);
        send(0, 8'h22, 3, acc);
        send(0, 8'h33, 3, acc);
        send(0, 8'h44, 3, acc);
        drain();
        chk("t4 word count", lg[0].size() - base, 4);
        chk("t4 word0", lg[0][base],   'h11);
        chk("t4 word1", lg[0][base+1], 'h22);
        chk("t4 word2", lg[0][base+2], 'h33);
        chk("t4 word3", lg[0][base+3], 'h44);

        // reset mid-word with a second word buffered
        send(0, 8'h99, 0, acc);
        vin[0] = 1'b1; din[0] = 8'h77;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        chk("t5 ready low with hold", int'(rout[0][5]), 0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5 serial_valid in reset", int'(rout[0][1]), 0);
        chk("t5 busy in reset", int'(rout[0][4]), 0);
        chk("t5 ready in reset", int'(rout[0][5]), 1);
        base = lg[0].size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h0F, 0, acc);
        drain();
        chk("t5 word count after reset", lg[0].size() - base, 1);
        chk("t5 word after reset", lg[0][$], 'h0F);

        // LSB first
        clrm(2); base = lg[2].size();
        send(2, 8'h01, 0, acc);
        drain();
        chk("t6 word", lg[2][base], 'h01);
        chk("t6 first bit", firstbit[2], 1);
        chk("t6 first cycle", first_c[2], acc);
        chk("t6 last-first span", last_c[2] - first_c[2], 7);

        // random words on all three configurations at once
        base = lg[0].size(); b1s = lg[1].size(); b2s = lg[2].size();
        fork
            stress(0);
            stress(1);
            stress(2);
        join
        drain();
        chk("stress cfg0 count", lg[0].size() - base, 25);
        chk("stress cfg1 count", lg[1].size() - b1s, 25);
        chk("stress cfg2 count", lg[2].size() - b2s, 25);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
